// File: rtl/div_sched.sv
// Divider-select controller: merges button, encoder, set and clear requests into one target
// value and hands it to the clock divider only on a period boundary (or after a timeout).
module div_sched #(
    parameter int W        = 3,
    parameter int HOLD_CYC = 25000000,
    parameter int REP_CYC  = 5000000,
    parameter int TMO_CYC  = 50000000,
    parameter int WRAP     = 0,
    parameter int SET_VAL  = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         up,
    input  logic         down,
    input  logic [1:0]   rlr,
    input  logic         set,
    input  logic         clr,
    input  logic         div_safe,
    output logic [W-1:0] target,
    output logic [W-1:0] div_out,
    output logic         div_pend,
    output logic         div_apply
);

    localparam int HMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
    localparam int HCW  = $clog2(HMAX + 1);
    localparam int TCW  = $clog2(TMO_CYC + 1);
    localparam logic [HCW-1:0] HOLD_V   = HCW'(HOLD_CYC);
    localparam logic [HCW-1:0] REP_V    = HCW'(REP_CYC);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TMO_CYC - 1);
    localparam logic [W-1:0]   MAX_V    = {W{1'b1}};
    localparam logic [W-1:0]   SET_V    = W'(SET_VAL);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    logic [1:0]     btn_s;
    logic           both_s;
    logic [1:0]     fire_s;
    logic [1:0]     prev_q, prev_d;
    logic [1:0]     act_q, act_d;
    logic [1:0]     rep_q, rep_d;
    logic [HCW-1:0] cnt_q [2];
    logic [HCW-1:0] cnt_d [2];
    logic [W-1:0]   target_q, target_d;
    logic [W-1:0]   div_out_q, div_out_d;
    logic           div_pend_q, div_pend_d;
    logic           div_apply_q, div_apply_d;
    logic [TCW-1:0] tmo_q, tmo_d;
    state_t         state_q, state_d;

    function automatic logic [W-1:0] step_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        if (v == MAX_V) begin
            r = (WRAP != 0) ? {W{1'b0}} : MAX_V;
        end else begin
            r = v + W'(1);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] step_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        if (v == {W{1'b0}}) begin
            r = (WRAP != 0) ? MAX_V : {W{1'b0}};
        end else begin
            r = v - W'(1);
        end
        return r;
    endfunction

    assign btn_s  = {down, up};
    assign both_s = up & down;

    // Per-button edge detect and hold-to-repeat timing; both buttons high cancels everything
    always_comb begin
        prev_d = btn_s;
        fire_s = 2'b00;
        act_d  = act_q;
        rep_d  = rep_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (both_s || !btn_s[i]) begin
                act_d[i] = 1'b0;
                rep_d[i] = 1'b0;
                cnt_d[i] = {HCW{1'b0}};
            end else if (!prev_q[i]) begin
                fire_s[i] = 1'b1;
                act_d[i]  = 1'b1;
                rep_d[i]  = 1'b0;
                cnt_d[i]  = HCW'(1);
            end else if (act_q[i]) begin
                if (!rep_q[i] && (cnt_q[i] == HOLD_V)) begin
                    fire_s[i] = 1'b1;
                    rep_d[i]  = 1'b1;
                    cnt_d[i]  = HCW'(1);
                end else if (rep_q[i] && (cnt_q[i] == REP_V)) begin
                    fire_s[i] = 1'b1;
                    cnt_d[i]  = HCW'(1);
                end else begin
                    cnt_d[i] = cnt_q[i] + HCW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Single target update per cycle; lower-priority requests in the same cycle are dropped
    always_comb begin
        target_d = target_q;
        if (clr) begin
            target_d = {W{1'b0}};
        end else if (set) begin
            target_d = SET_V;
        end else if (rlr == 2'b01) begin
            target_d = step_inc(target_q);
        end else if (rlr == 2'b10) begin
            target_d = step_dec(target_q);
        end else if (fire_s[0]) begin
            target_d = step_inc(target_q);
        end else if (fire_s[1]) begin
            target_d = step_dec(target_q);
        end else begin
            target_d = target_q;
        end
    end

    // Commit FSM: the registered target (pre-update value) is what reaches the divider
    always_comb begin
        state_d     = state_q;
        div_out_d   = div_out_q;
        div_apply_d = 1'b0;
        tmo_d       = {TCW{1'b0}};
        case (state_q)
            IDLE: begin
                if (target_q != div_out_q) begin
                    state_d = PEND;
                end else begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (target_q == div_out_q) begin
                    state_d = IDLE;
                end else if (div_safe || (tmo_q == TMO_LAST)) begin
                    div_out_d   = target_q;
                    div_apply_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        div_pend_d = (state_d == PEND);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= 2'b00;
            act_q       <= 2'b00;
            rep_q       <= 2'b00;
            cnt_q[0]    <= {HCW{1'b0}};
            cnt_q[1]    <= {HCW{1'b0}};
            target_q    <= {W{1'b0}};
            div_out_q   <= {W{1'b0}};
            div_pend_q  <= 1'b0;
            div_apply_q <= 1'b0;
            tmo_q       <= {TCW{1'b0}};
            state_q     <= IDLE;
        end else begin
            prev_q      <= prev_d;
            act_q       <= act_d;
            rep_q       <= rep_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            target_q    <= target_d;
            div_out_q   <= div_out_d;
            div_pend_q  <= div_pend_d;
            div_apply_q <= div_apply_d;
            tmo_q       <= tmo_d;
            state_q     <= state_d;
        end
    end

    assign target    = target_q;
    assign div_out   = div_out_q;
    assign div_pend  = div_pend_q;
    assign div_apply = div_apply_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: a saturating (WRAP=0) and a wrapping (WRAP=1) instance share stimulus
// and are checked against directed expectations and a cycle-level reference model.
module tb_div_sched;

    localparam int W    = 3;
    localparam int HOLD = 10;
    localparam int REP  = 4;
    localparam int TMO  = 20;
    localparam int SETV = 7;
    localparam int MAXV = 7;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       up       = 1'b0;
    logic       down     = 1'b0;
    logic [1:0] rlr      = 2'b00;
    logic       set      = 1'b0;
    logic       clr      = 1'b0;
    logic       div_safe = 1'b0;
    logic [W-1:0] t0, o0, t1, o1;
    logic         p0, a0, p1, a1;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state (index 0: saturating, 1: wrapping)
    int m_t [2] = '{0, 0};
    int m_o [2] = '{0, 0};
    int m_p [2] = '{0, 0};
    int m_a [2] = '{0, 0};
    int m_len [2] = '{0, 0};
    int up_prev = 0, dn_prev = 0;
    int up_len = -1, dn_len = -1;

    always #5 clk = ~clk;

    div_sched #(.W(W), .HOLD_CYC(HOLD), .REP_CYC(REP), .TMO_CYC(TMO), .WRAP(0), .SET_VAL(SETV)) u_sat (
        .clk(clk), .reset(reset), .up(up), .down(down), .rlr(rlr), .set(set), .clr(clr),
        .div_safe(div_safe), .target(t0), .div_out(o0), .div_pend(p0), .div_apply(a0)
    );

    div_sched #(.W(W), .HOLD_CYC(HOLD), .REP_CYC(REP), .TMO_CYC(TMO), .WRAP(1), .SET_VAL(SETV)) u_wrap (
        .clk(clk), .reset(reset), .up(up), .down(down), .rlr(rlr), .set(set), .clr(clr),
        .div_safe(div_safe), .target(t1), .div_out(o1), .div_pend(p1), .div_apply(a1)
    );

    function automatic logic [W-1:0] dut_t(input int i);
        return (i == 0) ? t0 : t1;
    endfunction
    function automatic logic [W-1:0] dut_o(input int i);
        return (i == 0) ? o0 : o1;
    endfunction
    function automatic logic dut_p(input int i);
        return (i == 0) ? p0 : p1;
    endfunction
    function automatic logic dut_a(input int i);
        return (i == 0) ? a0 : a1;
    endfunction

    // a held button fires at its edge, HOLD cycles later, then every REP cycles
    function automatic int fires(input int n);
        return (n == 0 || n == HOLD || (n > HOLD && ((n - HOLD) % REP) == 0)) ? 1 : 0;
    endfunction

    function automatic int arith(input int t, input int dir, input int wrap);
        if (dir > 0) return (t == MAXV) ? (wrap ? 0 : MAXV) : t + 1;
        else if (dir < 0) return (t == 0) ? (wrap ? MAXV : 0) : t - 1;
        else return t;
    endfunction

    task automatic model_update();
        int both, dir_b, dir_e, old_t, old_o;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_t[i] = 0; m_o[i] = 0; m_p[i] = 0; m_a[i] = 0; m_len[i] = 0;
            end
            up_prev = 0; dn_prev = 0; up_len = -1; dn_len = -1;
            return;
        end
        both = (up && down) ? 1 : 0;
        if (!up || both) up_len = -1;
        else if (!up_prev) up_len = 0;
        else if (up_len >= 0) up_len++;
        if (!down || both) dn_len = -1;
        else if (!dn_prev) dn_len = 0;
        else if (dn_len >= 0) dn_len++;
        dir_b = fires(up_len) ? 1 : (fires(dn_len) ? -1 : 0);
        dir_e = (rlr == 2'b01) ? 1 : ((rlr == 2'b10) ? -1 : 0);
        for (int i = 0; i < 2; i++) begin
            old_t = m_t[i];
            old_o = m_o[i];
            if (clr) m_t[i] = 0;
            else if (set) m_t[i] = SETV;
            else if (dir_e != 0) m_t[i] = arith(old_t, dir_e, i);
            else m_t[i] = arith(old_t, dir_b, i);
            m_a[i] = 0;
            if (!m_p[i]) begin
                if (old_t != old_o) begin m_p[i] = 1; m_len[i] = 0; end
            end else if (old_t == old_o) begin
                m_p[i] = 0;
            end else if (div_safe || (m_len[i] + 1 == TMO)) begin
                m_o[i] = old_t; m_a[i] = 1; m_p[i] = 0;
            end else begin
                m_len[i]++;
            end
        end
        up_prev = up ? 1 : 0;
        dn_prev = down ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic settle();
        clr = 1'b1; tick(); clr = 1'b0;
        div_safe = 1'b1; repeat (4) tick(); div_safe = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dut_t(i) !== 3'd0 || dut_o(i) !== 3'd0 || dut_p(i) !== 1'b0 || dut_a(i) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset[%0d]: got t=%0d o=%0d p=%0d a=%0d, expected all 0", i, dut_t(i), dut_o(i), dut_p(i), dut_a(i));
            end
        end
        reset = 1'b0; tick();
    endtask

    task automatic test_basic();
        rlr = 2'b01; tick(); rlr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dut_t(i) !== 3'd1) begin n_fail++; $display("FAIL basic_target[%0d]: got %0d expected 1", i, dut_t(i)); end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dut_p(i) !== 1'b1) begin n_fail++; $display("FAIL basic_pend[%0d]: got %0d expected 1", i, dut_p(i)); end
        end
        tick();
        div_safe = 1'b1; tick(); div_safe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dut_o(i) !== 3'd1 || dut_a(i) !== 1'b1 || dut_p(i) !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_commit[%0d]: got o=%0d a=%0d p=%0d expected o=1 a=1 p=0", i, dut_o(i), dut_a(i), dut_p(i));
            end
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dut_a(i) !== 1'b0 || dut_o(i) !== 3'd1) begin
                n_fail++; $display("FAIL basic_apply_once[%0d]: got a=%0d o=%0d expected a=0 o=1", i, dut_a(i), dut_o(i));
            end
        end
    endtask

    task automatic test_arith();
        int exp0 [4] = '{7, 7, 0, 0};
        int exp1 [4] = '{0, 1, 0, 7};
        logic [1:0] seq_rlr [4] = '{2'b01, 2'b01, 2'b00, 2'b10};
        set = 1'b1; tick(); set = 1'b0;
        n_tests++;
        if (t0 !== 3'd7 || t1 !== 3'd7) begin n_fail++; $display("FAIL arith_set: got %0d/%0d expected 7/7", t0, t1); end
        for (int k = 0; k < 4; k++) begin
            rlr = seq_rlr[k];
            clr = (k == 2) ? 1'b1 : 1'b0;
            tick();
            n_tests++;
            if (t0 !== 3'(exp0[k]) || t1 !== 3'(exp1[k])) begin
                n_fail++;
                $display("FAIL arith_step%0d: got sat=%0d wrap=%0d expected %0d/%0d", k, t0, t1, exp0[k], exp1[k]);
            end
        end
        rlr = 2'b00; clr = 1'b0;
    endtask

    task automatic test_repeat();
        int hits[$];
        int exp [6] = '{0, 10, 14, 18, 22, 26};
        logic [W-1:0] prev;
        int changes;
        settle();
        up = 1'b1;
        prev = t0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (t0 != prev) hits.push_back(k);
            prev = t0;
        end
        n_tests++;
        if (hits.size() != 6) begin n_fail++; $display("FAIL repeat_count: got %0d steps expected 6", hits.size()); end
        for (int j = 0; j < 6; j++) begin
            n_tests++;
            if (j >= hits.size() || hits[j] != exp[j]) begin
                n_fail++;
                $display("FAIL repeat_time%0d: got %0d expected %0d", j, (j < hits.size()) ? hits[j] : -1, exp[j]);
            end
        end
        n_tests++;
        if (t0 !== 3'd6 || t1 !== 3'd6) begin n_fail++; $display("FAIL repeat_value: got %0d/%0d expected 6/6", t0, t1); end
        up = 1'b0; tick();
        up = 1'b1; down = 1'b1;
        changes = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (t0 !== 3'd6) changes++; end
        down = 1'b0;
        for (int k = 0; k < 15; k++) begin tick(); if (t0 !== 3'd6) changes++; end
        n_tests++;
        if (changes != 0) begin n_fail++; $display("FAIL repeat_both_held: got %0d off-value cycles expected 0", changes); end
        up = 1'b0; tick();
    endtask

    task automatic test_priority();
        settle();
        up = 1'b1; rlr = 2'b10; set = 1'b1; tick();
        up = 1'b0; rlr = 2'b00; set = 1'b0;
        n_tests++;
        if (t0 !== 3'd7 || t1 !== 3'd7) begin n_fail++; $display("FAIL prio_set: got %0d/%0d expected 7/7", t0, t1); end
        tick();
        n_tests++;
        if (t0 !== 3'd7 || t1 !== 3'd7) begin n_fail++; $display("FAIL prio_dropped: got %0d/%0d expected 7/7", t0, t1); end
        up = 1'b1; rlr = 2'b10; tick();
        up = 1'b0; rlr = 2'b00;
        n_tests++;
        if (t0 !== 3'd6 || t1 !== 3'd6) begin n_fail++; $display("FAIL prio_enc_over_btn: got %0d/%0d expected 6/6", t0, t1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int ac = 0;
        settle();
        for (int k = 0; k < 3; k++) begin
            rlr = 2'b01; tick(); ac += a0;
            rlr = 2'b00; tick(); ac += a0;
        end
        n_tests++;
        if (o0 !== 3'd0 || ac != 0 || p0 !== 1'b1) begin
            n_fail++; $display("FAIL merge_hold: got o=%0d applies=%0d p=%0d expected o=0 applies=0 p=1", o0, ac, p0);
        end
        div_safe = 1'b1; tick(); div_safe = 1'b0;
        n_tests++;
        if (o0 !== 3'd3 || o1 !== 3'd3 || a0 !== 1'b1) begin
            n_fail++; $display("FAIL merge_commit: got o=%0d/%0d a=%0d expected 3/3 a=1", o0, o1, a0);
        end
        tick();
        n_tests++;
        if (a0 !== 1'b0 || p0 !== 1'b0) begin n_fail++; $display("FAIL merge_after: got a=%0d p=%0d expected 0/0", a0, p0); end
        ac = 0;
        rlr = 2'b01; tick(); ac += a0;
        rlr = 2'b00; tick(); ac += a0;
        n_tests++;
        if (p0 !== 1'b1) begin n_fail++; $display("FAIL cancel_pend: got %0d expected 1", p0); end
        rlr = 2'b10; tick(); ac += a0;
        rlr = 2'b00; tick(); ac += a0;
        tick(); ac += a0;
        n_tests++;
        if (p0 !== 1'b0 || o0 !== 3'd3 || ac != 0) begin
            n_fail++; $display("FAIL cancel_idle: got p=%0d o=%0d applies=%0d expected p=0 o=3 applies=0", p0, o0, ac);
        end
    endtask

    task automatic test_timeout();
        int pend_cnt = 0;
        int done = 0;
        rlr = 2'b01; tick(); rlr = 2'b00;
        for (int k = 0; k < 60 && done == 0; k++) begin
            tick();
            if (p0 === 1'b1) pend_cnt++;
            if (a0 === 1'b1) done = 1;
        end
        n_tests++;
        if (done == 0) begin n_fail++; $display("FAIL timeout_commit: got no apply within 60 cycles, expected one"); end
        n_tests++;
        if (pend_cnt != TMO || o0 !== 3'd4) begin
            n_fail++; $display("FAIL timeout_len: got pend=%0d cycles o=%0d expected %0d cycles o=4", pend_cnt, o0, TMO);
        end
    endtask

    task automatic test_reset_pend();
        rlr = 2'b01; tick(); rlr = 2'b00; tick(); tick();
        n_tests++;
        if (p0 !== 1'b1) begin n_fail++; $display("FAIL rstpend_setup: got p=%0d expected 1", p0); end
        reset = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (dut_t(i) !== 3'd0 || dut_o(i) !== 3'd0 || dut_p(i) !== 1'b0 || dut_a(i) !== 1'b0) begin
                n_fail++;
                $display("FAIL rstpend[%0d]: got t=%0d o=%0d p=%0d a=%0d expected all 0", i, dut_t(i), dut_o(i), dut_p(i), dut_a(i));
            end
        end
        reset = 1'b0; tick();
        n_tests++;
        if (a0 !== 1'b0 || a1 !== 1'b0 || p0 !== 1'b0 || o0 !== 3'd0) begin
            n_fail++; $display("FAIL rstpend_after: got a=%0d/%0d p=%0d o=%0d expected 0", a0, a1, p0, o0);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) up = ~up;
            if ($urandom_range(0, 15) == 0) down = ~down;
            rlr      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            set      = ($urandom_range(0, 39) == 0);
            clr      = ($urandom_range(0, 39) == 0);
            div_safe = ($urandom_range(0, (c < 1500) ? 5 : 39) == 0);
            reset    = ($urandom_range(0, 499) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (dut_t(i) !== 3'(m_t[i]) || dut_o(i) !== 3'(m_o[i]) ||
                    dut_p(i) !== 1'(m_p[i]) || dut_a(i) !== 1'(m_a[i])) begin
                    n_fail++;
                    if (bad < 10)
                        $display("FAIL random c=%0d inst%0d: got t=%0d o=%0d p=%0d a=%0d expected t=%0d o=%0d p=%0d a=%0d",
                                 c, i, dut_t(i), dut_o(i), dut_p(i), dut_a(i), m_t[i], m_o[i], m_p[i], m_a[i]);
                    bad++;
                end
            end
        end
        up = 1'b0; down = 1'b0; rlr = 2'b00; set = 1'b0; clr = 1'b0; div_safe = 1'b0; reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_repeat();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_pend();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
